// File: rtl/pcie_rx_ch_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_rx_ch_serializer_if
//  Description : Bundles the multi-channel AXI4-S RX input beat and the
//                single-channel AXI4-S TLP output stream of the serializer.
//                slave  - the serializer side (consumes in_*, drives out_*)
//                master - the surrounding logic (drives in_*, consumes out_*)
//  Signals     : in_tvalid/in_tready, in_ch_{valid,sop,eop,hdr,payload,user}
//                out_tvalid/out_tready, out_{sop,eop,hdr,payload,user}
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcie_rx_ch_serializer_if #(
    parameter int NUM_CH    = 2,
    parameter int HDR_W     = 128,
    parameter int PAYLOAD_W = 256,
    parameter int USER_W    = 16
);
    logic                        in_tvalid;
    logic                        in_tready;
    logic [NUM_CH-1:0]           in_ch_valid;
    logic [NUM_CH-1:0]           in_ch_sop;
    logic [NUM_CH-1:0]           in_ch_eop;
    logic [NUM_CH*HDR_W-1:0]     in_ch_hdr;
    logic [NUM_CH*PAYLOAD_W-1:0] in_ch_payload;
    logic [NUM_CH*USER_W-1:0]    in_ch_user;

    logic                        out_tvalid;
    logic                        out_tready;
    logic                        out_sop;
    logic                        out_eop;
    logic [HDR_W-1:0]            out_hdr;
    logic [PAYLOAD_W-1:0]        out_payload;
    logic [USER_W-1:0]           out_user;

    modport slave (
        input  in_tvalid, in_ch_valid, in_ch_sop, in_ch_eop,
               in_ch_hdr, in_ch_payload, in_ch_user, out_tready,
        output in_tready, out_tvalid, out_sop, out_eop,
               out_hdr, out_payload, out_user
    );

    modport master (
        output in_tvalid, in_ch_valid, in_ch_sop, in_ch_eop,
               in_ch_hdr, in_ch_payload, in_ch_user, out_tready,
        input  in_tready, out_tvalid, out_sop, out_eop,
               out_hdr, out_payload, out_user
    );
endinterface
`default_nettype wire

// File: rtl/pcie_rx_ch_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_rx_ch_serializer
//  Description : Serializes the 2-channel RX beat from the AVST-to-AXIS bridge
//                into a single-channel TLP stream, lowest channel first.
//                Holds one beat, backpressures upstream, drops beats with no
//                valid channel (counted) and flags SOP/EOP framing errors.
//  Ports       : avl_clk     - clock
//                avl_rst_n   - asynchronous active-low reset
//                bus         - in_*/out_* stream signals (slave modport)
//                drop_cnt    - saturating count of accepted empty beats
//                framing_err - sticky SOP/EOP framing violation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_rx_ch_serializer #(
    parameter int NUM_CH    = 2,
    parameter int HDR_W     = 128,
    parameter int PAYLOAD_W = 256,
    parameter int USER_W    = 16,
    parameter int CNT_W     = 16
) (
    input  wire logic               avl_clk,
    input  wire logic               avl_rst_n,
    pcie_rx_ch_serializer_if.slave  bus,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    framing_err
);
    localparam int c_SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Beat buffer (data only, never reset)
    logic                 r_sop     [NUM_CH];
    logic                 r_eop     [NUM_CH];
    logic [HDR_W-1:0]     r_hdr     [NUM_CH];
    logic [PAYLOAD_W-1:0] r_payload [NUM_CH];
    logic [USER_W-1:0]    r_user    [NUM_CH];

    // Control state
    logic [NUM_CH-1:0]    r_pend;
    logic                 r_in_pkt;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic                 r_framing_err;

    logic [c_SEL_W-1:0]   w_sel;
    logic                 w_one_pend;
    logic                 w_in_tready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_seg_err;

    // Lowest pending channel is the one on the output.
    always_comb begin
        w_sel = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (r_pend[c]) begin
                w_sel = c_SEL_W'(c);
            end
        end
    end

    assign w_one_pend  = (r_pend != '0) && ((r_pend & (r_pend - NUM_CH'(1))) == '0);
    // A new beat may enter while the last pending segment is leaving.
    assign w_in_tready = (r_pend == '0) | (bus.out_tready & w_one_pend);
    assign w_in_fire   = bus.in_tvalid & w_in_tready;
    assign w_out_fire  = bus.out_tvalid & bus.out_tready;

    // A SOP must arrive outside a packet, a non-SOP segment inside one.
    assign w_seg_err = (bus.out_sop & r_in_pkt) | (~bus.out_sop & ~r_in_pkt);

    assign bus.in_tready   = w_in_tready;
    assign bus.out_tvalid  = |r_pend;
    assign bus.out_sop     = r_sop[w_sel];
    assign bus.out_eop     = r_eop[w_sel];
    assign bus.out_hdr     = r_hdr[w_sel];
    assign bus.out_payload = r_payload[w_sel];
    assign bus.out_user    = r_user[w_sel];
    assign drop_cnt        = r_drop_cnt;
    assign framing_err     = r_framing_err;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_buf
            always_ff @(posedge avl_clk) begin
                if (w_in_fire) begin
                    r_sop[c]     <= bus.in_ch_sop[c];
                    r_eop[c]     <= bus.in_ch_eop[c];
                    r_hdr[c]     <= bus.in_ch_hdr[c*HDR_W +: HDR_W];
                    r_payload[c] <= bus.in_ch_payload[c*PAYLOAD_W +: PAYLOAD_W];
                    r_user[c]    <= bus.in_ch_user[c*USER_W +: USER_W];
                end
            end
        end
    endgenerate

    always_ff @(posedge avl_clk or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            r_pend        <= '0;
            r_in_pkt      <= 1'b0;
            r_drop_cnt    <= '0;
            r_framing_err <= 1'b0;
        end else begin
            // Load wins over clearing the last pending bit in the same cycle.
            if (w_in_fire) begin
                r_pend <= bus.in_ch_valid;
            end else if (w_out_fire) begin
                r_pend <= r_pend & ~(NUM_CH'(1) << w_sel);
            end

            if (w_in_fire && (bus.in_ch_valid == '0) && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end

            if (w_out_fire) begin
                if (w_seg_err) begin
                    r_framing_err <= 1'b1;
                end
                if (bus.out_eop) begin
                    r_in_pkt <= 1'b0;
                end else if (bus.out_sop) begin
                    r_in_pkt <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pcie_rx_ch_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcie_rx_ch_serializer
//  Description : Self-checking bench for pcie_rx_ch_serializer. A queue of
//                expected output segments, a drop counter and a framing flag
//                form the reference; directed scenarios plus random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_rx_ch_serializer;
    localparam int NUM_CH    = 2;
    localparam int HDR_W     = 128;
    localparam int PAYLOAD_W = 256;
    localparam int USER_W    = 16;
    localparam int CNT_W     = 8;

    logic avl_clk   = 1'b0;
    logic avl_rst_n = 1'b0;
    logic [CNT_W-1:0] drop_cnt;
    logic             framing_err;

    always #5 avl_clk = ~avl_clk;

    pcie_rx_ch_serializer_if #(
        .NUM_CH(NUM_CH), .HDR_W(HDR_W), .PAYLOAD_W(PAYLOAD_W), .USER_W(USER_W)
    ) bus ();

    pcie_rx_ch_serializer #(
        .NUM_CH(NUM_CH), .HDR_W(HDR_W), .PAYLOAD_W(PAYLOAD_W),
        .USER_W(USER_W), .CNT_W(CNT_W)
    ) dut (
        .avl_clk     (avl_clk),
        .avl_rst_n   (avl_rst_n),
        .bus         (bus),
        .drop_cnt    (drop_cnt),
        .framing_err (framing_err)
    );

    typedef struct {
        logic                 sop;
        logic                 eop;
        logic [HDR_W-1:0]     hdr;
        logic [PAYLOAD_W-1:0] payload;
        logic [USER_W-1:0]    user;
    } seg_t;

    seg_t             exp_q[$];
    logic             m_in_pkt;
    logic             m_err;
    int               m_drop;
    int               n_cmp  = 0;
    int               n_fail = 0;
    int               out_cnt   = 0;
    int               stall_cnt = 0;
    int               rdy_mode  = 0;
    logic [3:0]       rdy_pat   = 4'b1010;
    bit               h0_seen   = 0;
    logic             h0_rdy    = 1'b1;
    bit               gen_in_pkt = 0;

    localparam logic [HDR_W-1:0] H0 = {32'hA0A0_0001, 96'h0};
    localparam logic [HDR_W-1:0] H1 = {32'hB1B1_0002, 96'h0};

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model and per-cycle compare; inputs and outputs are stable here.
    always @(negedge avl_clk) begin
        if (!avl_rst_n) begin
            exp_q.delete();
            m_in_pkt = 1'b0;
            m_err    = 1'b0;
            m_drop   = 0;
            check("rst_tvalid", bus.out_tvalid, 1'b0);
            check("rst_drop", drop_cnt, '0);
            check("rst_err", framing_err, 1'b0);
        end else begin
            check("out_tvalid", bus.out_tvalid, exp_q.size() != 0);
            check("in_tready", bus.in_tready,
                  (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_tready));
            check("drop_cnt", drop_cnt, m_drop[CNT_W-1:0]);
            check("framing_err", framing_err, m_err);
            if (bus.in_tvalid && !bus.in_tready) stall_cnt++;
            if (bus.out_tvalid && bus.out_sop && bus.out_eop && bus.out_hdr == H0) begin
                h0_seen = 1;
                h0_rdy  = bus.in_tready;
            end
            if (bus.out_tvalid && exp_q.size() > 0) begin
                check("out_sop", bus.out_sop, exp_q[0].sop);
                check("out_eop", bus.out_eop, exp_q[0].eop);
                check("out_payload", bus.out_payload, exp_q[0].payload);
                check("out_user", bus.out_user, exp_q[0].user);
                if (exp_q[0].sop) check("out_hdr", bus.out_hdr, exp_q[0].hdr);
            end
            if (bus.out_tvalid && bus.out_tready && exp_q.size() > 0) begin
                seg_t s;
                s = exp_q.pop_front();
                out_cnt++;
                if (s.sop == m_in_pkt) m_err = 1'b1;
                if (s.eop) m_in_pkt = 1'b0;
                else if (s.sop) m_in_pkt = 1'b1;
            end
            if (bus.in_tvalid && bus.in_tready) begin
                if (bus.in_ch_valid == '0) begin
                    if (m_drop < (1 << CNT_W) - 1) m_drop++;
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (bus.in_ch_valid[c]) begin
                        seg_t s;
                        s.sop     = bus.in_ch_sop[c];
                        s.eop     = bus.in_ch_eop[c];
                        s.hdr     = bus.in_ch_hdr[c*HDR_W +: HDR_W];
                        s.payload = bus.in_ch_payload[c*PAYLOAD_W +: PAYLOAD_W];
                        s.user    = bus.in_ch_user[c*USER_W +: USER_W];
                        exp_q.push_back(s);
                    end
                end
            end
        end
    end

    // Downstream ready generator; mode 4 leaves out_tready to the main sequence.
    initial begin
        bus.out_tready = 1'b1;
        forever begin
            @(posedge avl_clk);
            #1;
            case (rdy_mode)
                0: bus.out_tready = 1'b1;
                1: bus.out_tready = 1'($urandom_range(0, 1));
                2: begin
                    bus.out_tready = rdy_pat[3];
                    rdy_pat = {rdy_pat[2:0], rdy_pat[3]};
                end
                3: bus.out_tready = 1'b0;
                default: ;
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                             input logic [HDR_W-1:0] h0, input logic [HDR_W-1:0] h1);
        bit ok = 0;
        bus.in_tvalid   = 1'b1;
        bus.in_ch_valid = v;
        bus.in_ch_sop   = s;
        bus.in_ch_eop   = e;
        bus.in_ch_hdr   = {h1, h0};
        for (int i = 0; i < NUM_CH * PAYLOAD_W / 32; i++) bus.in_ch_payload[i*32 +: 32] = $urandom;
        for (int i = 0; i < NUM_CH; i++) bus.in_ch_user[i*USER_W +: USER_W] = USER_W'($urandom);
        for (int t = 0; t < 200; t++) begin
            @(negedge avl_clk);
            if (bus.in_tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: beat not accepted within 200 cycles at %0t", $time);
        end
        @(posedge avl_clk);
        #1;
        bus.in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge avl_clk);
        #1;
    endtask

    task automatic rand_beat(input bit wellformed);
        logic [1:0] v, s, e;
        logic [HDR_W-1:0] h0, h1;
        v = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        s = 2'($urandom);
        e = 2'($urandom);
        h0 = {$urandom, $urandom, $urandom, $urandom};
        h1 = {$urandom, $urandom, $urandom, $urandom};
        if (wellformed) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (v[c]) begin
                    s[c] = !gen_in_pkt;
                    gen_in_pkt = !e[c];
                end
            end
        end
        send_beat(v, s, e, h0, h1);
        if ($urandom_range(0, 3) == 0) idle(1);
    endtask

    task automatic do_reset;
        @(negedge avl_clk);
        #2 avl_rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", bus.out_tvalid, 1'b0);
        check("async_rst_tready", bus.in_tready, 1'b1);
        repeat (2) @(posedge avl_clk);
        #1 avl_rst_n = 1'b1;
        gen_in_pkt = 0;
    endtask

    initial begin
        int base;
        bus.in_tvalid     = 1'b0;
        bus.in_ch_valid   = '0;
        bus.in_ch_sop     = '0;
        bus.in_ch_eop     = '0;
        bus.in_ch_hdr     = '0;
        bus.in_ch_payload = '0;
        bus.in_ch_user    = '0;
        repeat (3) @(posedge avl_clk);
        #1 avl_rst_n = 1'b1;
        idle(1);
        check("reset_tvalid", bus.out_tvalid, 1'b0);
        check("reset_tready", bus.in_tready, 1'b1);
        check("reset_drop", drop_cnt, 8'd0);
        check("reset_err", framing_err, 1'b0);

        // Single-channel back-to-back stream
        base = out_cnt;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) send_beat(2'b01, 2'b01, 2'b01, H1, H0);
        idle(3);
        check("single_out_cnt", out_cnt - base, 4);
        check("single_stalls", stall_cnt, 0);
        check("single_err", framing_err, 1'b0);

        // Dual-channel beat followed by the CH1 packet's EOP
        base = out_cnt;
        send_beat(2'b11, 2'b11, 2'b01, H0, H1);
        send_beat(2'b01, 2'b00, 2'b01, H1, H1);
        idle(3);
        check("dual_out_cnt", out_cnt - base, 3);
        check("dual_h0_seen", h0_seen, 1'b1);
        check("dual_h0_tready", h0_rdy, 1'b0);
        check("dual_err", framing_err, 1'b0);

        // Backpressure 1010 during a dual-channel packet
        base = out_cnt;
        rdy_pat  = 4'b1010;
        rdy_mode = 2;
        send_beat(2'b11, 2'b01, 2'b10, H0, H1);
        idle(8);
        rdy_mode = 0;
        idle(2);
        check("bp_out_cnt", out_cnt - base, 2);
        check("bp_err", framing_err, 1'b0);

        // Empty beats and counter saturation
        base = out_cnt;
        for (int i = 0; i < 3; i++) send_beat(2'b00, 2'b11, 2'b11, H0, H1);
        idle(2);
        check("empty_drop3", drop_cnt, 8'd3);
        check("empty_no_out", out_cnt - base, 0);
        for (int i = 0; i < 252; i++) send_beat(2'b00, 2'b00, 2'b00, H0, H1);
        idle(2);
        check("drop_sat", drop_cnt, 8'hFF);
        for (int i = 0; i < 5; i++) send_beat(2'b00, 2'b00, 2'b00, H0, H1);
        idle(2);
        check("drop_hold", drop_cnt, 8'hFF);

        // Two SOP-only segments without an EOP in between
        base = out_cnt;
        send_beat(2'b01, 2'b01, 2'b00, H0, H1);
        idle(2);
        check("frm_first_ok", framing_err, 1'b0);
        send_beat(2'b01, 2'b01, 2'b00, H1, H0);
        idle(2);
        check("frm_set", framing_err, 1'b1);
        check("frm_forwarded", out_cnt - base, 2);
        send_beat(2'b01, 2'b00, 2'b01, H0, H0);
        idle(3);
        check("frm_sticky", framing_err, 1'b1);

        // Reset with CH1 still pending
        rdy_mode = 4;
        bus.out_tready = 1'b0;
        send_beat(2'b11, 2'b01, 2'b10, H0, H1);
        bus.out_tready = 1'b1;
        idle(1);
        bus.out_tready = 1'b0;
        @(negedge avl_clk);
        check("mid_pend_valid", bus.out_tvalid, 1'b1);
        do_reset();
        bus.out_tready = 1'b1;
        base = out_cnt;
        idle(4);
        check("post_rst_no_out", out_cnt - base, 0);
        check("post_rst_err", framing_err, 1'b0);
        check("post_rst_tready", bus.in_tready, 1'b1);

        // Random well-formed traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 1500; i++) rand_beat(1);
        rdy_mode = 0;
        idle(4);
        check("wf_err_clear", framing_err, 1'b0);

        // Fully random framing
        rdy_mode = 1;
        for (int i = 0; i < 1500; i++) rand_beat(0);
        rdy_mode = 0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/pcie_rx_ch_serializer.md
Name: pcie_rx_ch_serializer

Overview:
- Sits directly downstream of the H-tile RX AVST-to-AXIS bridge.
- Consumes the bridge's 2-channel AXI4-S RX beat, where each channel carries one TLP segment with hdr, payload, sop, eop and valid.
- Emits a single-channel AXI4-S TLP stream, one channel segment per beat, in channel order CH0 then CH1.
- Buffers one input beat, applies backpressure upstream, drops empty beats and flags SOP/EOP framing violations.

Parameters:
- NUM_CH, 2, number of input TLP channels per beat; only 2 is supported.
- HDR_W, 128, header width per channel in bits.
- PAYLOAD_W, 256, payload width per channel in bits.
- USER_W, 16, per-channel tuser width in bits, passed through opaquely.
- CNT_W, 16, width of the dropped-beat counter.

Ports:
- avl_clk  in  1  clock.
- avl_rst_n  in  1  asynchronous active-low reset.
- in_tvalid  in  1  input beat valid.
- in_tready  out  1  input beat accepted when in_tvalid & in_tready.
- in_ch_valid  in  NUM_CH  per-channel segment valid.
- in_ch_sop  in  NUM_CH  per-channel start of TLP.
- in_ch_eop  in  NUM_CH  per-channel end of TLP.
- in_ch_hdr  in  NUM_CH*HDR_W  per-channel header; channel c at [c*HDR_W +: HDR_W].
- in_ch_payload  in  NUM_CH*PAYLOAD_W  per-channel payload.
- in_ch_user  in  NUM_CH*USER_W  per-channel tuser.
- out_tvalid  out  1  output segment valid.
- out_tready  in  1  downstream ready.
- out_sop  out  1  start of TLP.
- out_eop  out  1  end of TLP.
- out_hdr  out  HDR_W  header; meaningful only when out_sop=1.
- out_payload  out  PAYLOAD_W  payload.
- out_user  out  USER_W  tuser.
- drop_cnt  out  CNT_W  saturating count of accepted beats with in_ch_valid==0.
- framing_err  out  1  sticky framing violation flag.

Behaviour:
- Reset (async assert, sync-released by the clock domain):
  - out_tvalid=0, pend mask=0, in_pkt=0, drop_cnt=0, framing_err=0.
  - Data registers are not reset.
- Internal state:
  - One beat buffer holding all channel fields.
  - pend[NUM_CH] marks channels not yet emitted.
  - Current segment index sel is the lowest set bit of pend.
- Outputs:
  - out_tvalid = |pend.
  - out_* fields are muxed from the buffer at sel.
  - All outputs are driven from registers and the sel mux only; there is no combinational path from in_* to out_*.
- Output handshake: when out_tvalid & out_tready, clear pend[sel].
- in_tready = (pend==0) | (out_tready & pend has exactly one bit set). This gives a combinational path from out_tready to in_tready.
- Input accept (in_tvalid & in_tready):
  - Load the buffer and set pend = in_ch_valid.
  - Same-cycle load wins over the clear of the last pending bit.
- Latency: 1 cycle from accept to out_tvalid.
- Throughput:
  - One input beat per cycle when each beat has a single valid channel.
  - Two cycles per beat when both channels are valid.
- Empty beat (accepted with in_ch_valid==0):
  - Nothing is emitted; pend stays 0.
  - drop_cnt increments and saturates at all-ones, with no wrap.
- Framing check, evaluated on each output handshake:
  - out_sop & in_pkt & ~prior eop → set framing_err.
  - ~out_sop & ~in_pkt → set framing_err.
  - in_pkt is set by sop & ~eop and cleared by eop.
  - A single-segment TLP (sop & eop) leaves in_pkt=0.
  - framing_err clears only on reset.
  - Segments are always forwarded unchanged, even when the check fails.
- Output stability: while out_tvalid=1 and out_tready=0, all out_* fields must hold stable.
- Channel order: CH0 segment always precedes the CH1 segment of the same beat, regardless of sop/eop placement.
- Reset mid-operation: pending segments are discarded; no partial TLP is emitted after reset release.

Test Plan:
- Single-channel stream: 4 beats with in_ch_valid=01, SOP+EOP each, out_tready=1 → 4 output beats on consecutive cycles, 1-cycle latency, in_tready held 1, framing_err=0.
- Dual-channel beat: in_ch_valid=11, CH0 sop/eop=1/1 hdr=H0, CH1 sop/eop=1/0 hdr=H1, followed by a beat with CH0 eop → outputs H0(sop,eop), H1(sop), then eop segment. in_tready=0 on the cycle CH0 is emitted.
- Backpressure: out_tready toggles 1010 during a dual-channel beat → each segment is emitted exactly once, out_* stable while stalled, no beat lost or duplicated.
- Empty beats: 3 accepted beats with in_ch_valid=00 → no out_tvalid, drop_cnt=3. Preload drop_cnt at 0xFFFF and drop again → stays at 0xFFFF.
- Framing error: two SOP-only segments with no intervening EOP → framing_err=1 after the second handshake and stays 1 until reset; both segments still appear on the output.
- Reset mid-packet: assert avl_rst_n=0 while pend=10 → out_tvalid=0 immediately (async). After release, in_tready=1 and no stale CH1 segment is emitted.
